// File: rtl/tetris_lcd_pkg.sv
// Shared LCD definitions for the frame sequencer: command codes, default
// panel geometry and the FSM state encoding.
package tetris_lcd_pkg;

  localparam int DEFAULT_H_RES = 128;
  localparam int DEFAULT_V_RES = 160;

  localparam logic [7:0] CMD_CASET = 8'h2A;
  localparam logic [7:0] CMD_RASET = 8'h2B;
  localparam logic [7:0] CMD_RAMWR = 8'h2C;

  // Window sequence is 11 bytes: indices 0..10.
  localparam logic [3:0] WIN_CMD_LAST = 4'd10;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CMD  = 3'd1,
    ST_PREQ = 3'd2,
    ST_PCAP = 3'd3,
    ST_PHI  = 3'd4,
    ST_PLO  = 3'd5,
    ST_DONE = 3'd6
  } state_t;

endpackage

// File: rtl/tetris_window_cmd_rom.sv
// Window-setup byte ROM: CASET / RASET spanning the full panel, then RAMWR.
// Output is {dc, data}; dc=0 marks a command byte.
module tetris_window_cmd_rom
  import tetris_lcd_pkg::*;
#(
  parameter int H_RES = DEFAULT_H_RES,
  parameter int V_RES = DEFAULT_V_RES
) (
  input  logic [3:0] idx,
  output logic       dc,
  output logic [7:0] data
);

  localparam logic [15:0] XE = 16'(H_RES - 1);
  localparam logic [15:0] YE = 16'(V_RES - 1);

  always_comb begin
    dc   = 1'b0;
    data = 8'h00;
    case (idx)
      4'd0:  begin dc = 1'b0; data = CMD_CASET;  end
      4'd1:  begin dc = 1'b1; data = 8'h00;      end
      4'd2:  begin dc = 1'b1; data = 8'h00;      end
      4'd3:  begin dc = 1'b1; data = XE[15:8];   end
      4'd4:  begin dc = 1'b1; data = XE[7:0];    end
      4'd5:  begin dc = 1'b0; data = CMD_RASET;  end
      4'd6:  begin dc = 1'b1; data = 8'h00;      end
      4'd7:  begin dc = 1'b1; data = 8'h00;      end
      4'd8:  begin dc = 1'b1; data = YE[15:8];   end
      4'd9:  begin dc = 1'b1; data = YE[7:0];    end
      4'd10: begin dc = 1'b0; data = CMD_RAMWR;  end
      default: begin dc = 1'b0; data = 8'h00;    end
    endcase
  end

endmodule

// File: rtl/tetris_frame_sequencer.sv
// Streams one full LCD frame over a byte-wide SPI handshake: window setup
// commands, then every pixel fetched from the renderer as two RGB565 bytes.
//
// state | meaning
// IDLE  | waiting for frame_start
// CMD   | sending the 11-byte window/RAMWR sequence
// PREQ  | one-cycle render strobe for (pix_x, pix_y)
// PCAP  | capture renderer pixel into buffer
// PHI   | send buffer[15:8]
// PLO   | send buffer[7:0], then advance pixel position
// DONE  | one-cycle frame_done pulse
module tetris_frame_sequencer
  import tetris_lcd_pkg::*;
#(
  parameter int H_RES = DEFAULT_H_RES,
  parameter int V_RES = DEFAULT_V_RES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_start,
  output logic        busy,
  output logic        frame_done,
  output logic [12:0] pix_x,
  output logic [12:0] pix_y,
  output logic        pix_req,
  input  logic [15:0] pix_data,
  output logic        spi_valid,
  output logic [7:0]  spi_data,
  output logic        spi_dc,
  input  logic        spi_ready
);

  localparam logic [12:0] X_LAST = 13'(H_RES - 1);
  localparam logic [12:0] Y_LAST = 13'(V_RES - 1);

  state_t      state, state_next;
  logic [3:0]  cmd_idx;
  logic [15:0] pix_buf;
  logic        rom_dc;
  logic [7:0]  rom_data;
  logic        xfer;
  logic        last_x, last_y;

  tetris_window_cmd_rom #(
    .H_RES(H_RES),
    .V_RES(V_RES)
  ) u_cmd_rom (
    .idx (cmd_idx),
    .dc  (rom_dc),
    .data(rom_data)
  );

  assign xfer   = spi_valid && spi_ready;
  assign last_x = (pix_x == X_LAST);
  assign last_y = (pix_y == Y_LAST);

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (frame_start) state_next = ST_CMD;
      ST_CMD:  if (xfer && cmd_idx == WIN_CMD_LAST) state_next = ST_PREQ;
      ST_PREQ: state_next = ST_PCAP;
      ST_PCAP: state_next = ST_PHI;
      ST_PHI:  if (xfer) state_next = ST_PLO;
      ST_PLO:  if (xfer) state_next = (last_x && last_y) ? ST_DONE : ST_PREQ;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    busy       = 1'b1;
    frame_done = 1'b0;
    pix_req    = 1'b0;
    spi_valid  = 1'b0;
    spi_data   = 8'h00;
    spi_dc     = 1'b0;
    case (state)
      ST_IDLE: busy = 1'b0;
      ST_CMD: begin
        spi_valid = 1'b1;
        spi_data  = rom_data;
        spi_dc    = rom_dc;
      end
      ST_PREQ: pix_req = 1'b1;
      ST_PCAP: ;
      ST_PHI: begin
        spi_valid = 1'b1;
        spi_data  = pix_buf[15:8];
        spi_dc    = 1'b1;
      end
      ST_PLO: begin
        spi_valid = 1'b1;
        spi_data  = pix_buf[7:0];
        spi_dc    = 1'b1;
      end
      ST_DONE: begin
        busy       = 1'b0;
        frame_done = 1'b1;
      end
      default: busy = 1'b0;
    endcase
  end

  // Datapath only moves on handshakes, so a stalled SPI engine freezes everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      cmd_idx <= 4'd0;
      pix_x   <= 13'd0;
      pix_y   <= 13'd0;
      pix_buf <= 16'h0000;
    end else begin
      case (state)
        ST_IDLE: begin
          if (frame_start) begin
            cmd_idx <= 4'd0;
            pix_x   <= 13'd0;
            pix_y   <= 13'd0;
          end
        end
        ST_CMD:  if (xfer && cmd_idx != WIN_CMD_LAST) cmd_idx <= cmd_idx + 4'd1;
        ST_PCAP: pix_buf <= pix_data;
        ST_PLO: begin
          if (xfer) begin
            if (!last_x) begin
              pix_x <= pix_x + 13'd1;
            end else if (!last_y) begin
              pix_x <= 13'd0;
              pix_y <= pix_y + 13'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tetris_frame_sequencer.sv
// Scoreboard bench for the frame sequencer: expected SPI bytes and render
// coordinates are queued by the stimulus, a negedge monitor pops and compares.
module tb_tetris_frame_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        frame_start = 1'b0;
  logic        busy, frame_done, pix_req, spi_valid, spi_dc;
  logic [12:0] pix_x, pix_y;
  logic [15:0] pix_data = 16'h0000;
  logic [7:0]  spi_data;
  logic        spi_ready = 1'b1;

  int n_cmp = 0;
  int n_bad = 0;
  int frame_done_cnt = 0;
  int busy_cycles = 0;
  int pixreq_cnt = 0;

  logic [8:0]  exp_byte_q[$];
  logic [25:0] exp_pix_q[$];

  always #5 clk = ~clk;

  tetris_frame_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .frame_start(frame_start),
    .busy       (busy),
    .frame_done (frame_done),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .pix_req    (pix_req),
    .pix_data   (pix_data),
    .spi_valid  (spi_valid),
    .spi_data   (spi_data),
    .spi_dc     (spi_dc),
    .spi_ready  (spi_ready)
  );

  // Renderer model: answers a strobe with {x[7:0], y[7:0]} on the next cycle.
  always @(posedge clk) if (pix_req) pix_data <= {pix_x[7:0], pix_y[7:0]};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 20) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (busy) busy_cycles++;
    if (frame_done) frame_done_cnt++;
    if (pix_req) begin
      pixreq_cnt++;
      if (exp_pix_q.size() == 0) check("pix_req_unexpected", 32'd1, 32'd0);
      else check("pix_req_xy", {6'd0, pix_x, pix_y}, {6'd0, exp_pix_q.pop_front()});
    end
    if (spi_valid && spi_ready) begin
      if (exp_byte_q.size() == 0) check("spi_unexpected", 32'd1, 32'd0);
      else check("spi_byte", {23'd0, spi_dc, spi_data}, {23'd0, exp_byte_q.pop_front()});
    end
  end

  task automatic push_frame();
    logic [12:0] x13, y13;
    exp_byte_q.push_back(9'h02A); exp_byte_q.push_back(9'h100);
    exp_byte_q.push_back(9'h100); exp_byte_q.push_back(9'h100);
    exp_byte_q.push_back(9'h17F); exp_byte_q.push_back(9'h02B);
    exp_byte_q.push_back(9'h100); exp_byte_q.push_back(9'h100);
    exp_byte_q.push_back(9'h100); exp_byte_q.push_back(9'h19F);
    exp_byte_q.push_back(9'h02C);
    for (int y = 0; y < 160; y++) begin
      for (int x = 0; x < 128; x++) begin
        x13 = 13'(x);
        y13 = 13'(y);
        exp_pix_q.push_back({x13, y13});
        exp_byte_q.push_back({1'b1, x13[7:0]});
        exp_byte_q.push_back({1'b1, y13[7:0]});
      end
    end
  endtask

  task automatic wait_pix(input logic [12:0] x, input logic [12:0] y, input int limit);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < limit && !hit; i++) begin
      @(negedge clk);
      if (pix_req && pix_x == x && pix_y == y) hit = 1'b1;
    end
    if (!hit) check("wait_pix_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    bit got_done;
    repeat (3) @(negedge clk);
    check("rst_outputs", {26'd0, busy, frame_done, pix_req, spi_valid, spi_dc, 1'b0}, 32'd0);
    check("rst_spi_data", {24'd0, spi_data}, 32'd0);
    check("rst_pix_xy", {6'd0, pix_x, pix_y}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Frame aborted by reset at pixel (10,3)
    push_frame();
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    wait_pix(13'd10, 13'd3, 5000);
    reset = 1'b1;
    @(negedge clk);
    check("abort_spi_valid", {31'd0, spi_valid}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_pix_req", {31'd0, pix_req}, 32'd0);
    check("abort_pix_xy", {6'd0, pix_x, pix_y}, 32'd0);
    reset = 1'b0;
    exp_byte_q.delete();
    exp_pix_q.delete();
    repeat (3) @(negedge clk);
    check("abort_no_frame_done", frame_done_cnt, 32'd0);

    // Full frame with busy-time frame_start pulses and a PHI stall
    busy_cycles = 0;
    frame_done_cnt = 0;
    pixreq_cnt = 0;
    push_frame();
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    check("first_byte_2a", {22'd0, spi_valid, spi_dc, spi_data}, 32'h22A);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      frame_start = 1'b1;
      @(negedge clk);
      frame_start = 1'b0;
    end

    wait_pix(13'd20, 13'd2, 3000);
    spi_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("stall_phi_byte", {22'd0, spi_valid, spi_dc, spi_data}, 32'h314);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("stall_stable", {22'd0, spi_valid, spi_dc, spi_data}, 32'h314);
      check("stall_no_pix_req", {31'd0, pix_req}, 32'd0);
    end
    spi_ready = 1'b1;

    got_done = 1'b0;
    for (int i = 0; i < 90000 && !got_done; i++) begin
      @(negedge clk);
      if (frame_done) got_done = 1'b1;
    end
    if (!got_done) check("frame_done_timeout", 32'd0, 32'd1);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    check("done_start_ignored", {31'd0, busy}, 32'd0);
    repeat (5) @(negedge clk);
    check("idle_after_done", {30'd0, busy, spi_valid}, 32'd0);
    check("frame_done_count", frame_done_cnt, 32'd1);
    check("pix_req_count", pixreq_cnt, 32'd20480);
    check("busy_cycles", busy_cycles, 32'd81941);
    check("bytes_left", exp_byte_q.size(), 32'd0);
    check("pix_left", exp_pix_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/tetris_frame_sequencer.md
TETRIS_FRAME_SEQUENCER -- requirements
Module: tetris_frame_sequencer

Interface
REQ-001 Parameter H_RES, default 128, pixels per line.
REQ-002 Parameter V_RES, default 160, lines per frame.
REQ-003 Port clk  input  1  sole clock; all logic on its rising edge.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port frame_start  input  1  single-cycle request to refresh one full frame.
REQ-006 Port busy  output  1  high from frame acceptance until frame_done.
REQ-007 Port frame_done  output  1  one-cycle pulse after the last pixel byte transfers.
REQ-008 Port pix_x  output  13  pixel column presented to the video renderer.
REQ-009 Port pix_y  output  13  pixel row presented to the video renderer.
REQ-010 Port pix_req  output  1  one-cycle render strobe; the renderer registers the pixel on that edge.
REQ-011 Port pix_data  input  16  RGB565 from the renderer, valid the cycle after pix_req.
REQ-012 Port spi_valid  output  1  byte available to the SPI byte engine.
REQ-013 Port spi_data  output  8  byte to transmit.
REQ-014 Port spi_dc  output  1  0 = command byte, 1 = data byte.
REQ-015 Port spi_ready  input  1  SPI engine can accept a byte.

Function
REQ-016 SPI handshake: a byte transfers on an edge where spi_valid and spi_ready are both high; spi_data and spi_dc SHALL stay stable while spi_valid is high and the byte has not transferred.
REQ-017 FSM states: IDLE, CMD, PREQ, PCAP, PHI, PLO, DONE.
REQ-018 IDLE: frame_start is accepted only in IDLE; acceptance clears the byte index and pix_x/pix_y to 0 and moves the FSM to CMD.
REQ-019 CMD streams 11 bytes in order, with dc shown after each slash: 2A/0, 00/1, 00/1, XE_hi/1, XE_lo/1, 2B/0, 00/1, 00/1, YE_hi/1, YE_lo/1, 2C/0.
REQ-020 XE = H_RES-1 and YE = V_RES-1, each split into high and low bytes.
REQ-021 After the 2C byte transfers, the FSM moves to PREQ.
REQ-022 PREQ: assert pix_req for exactly one cycle with pix_x/pix_y stable, then go to PCAP.
REQ-023 PCAP: latch pix_data into a 16-bit buffer, then go to PHI.
REQ-024 PHI: present buffer[15:8] with dc=1.
REQ-025 PLO: present buffer[7:0] with dc=1.
REQ-026 Each of PHI and PLO advances only on transfer.
REQ-027 On the PLO transfer with pix_x < H_RES-1: pix_x increments and the FSM goes to PREQ.
REQ-028 On the PLO transfer with pix_x = H_RES-1 and pix_y < V_RES-1: pix_x becomes 0, pix_y increments and the FSM goes to PREQ.
REQ-029 On the PLO transfer with pix_x = H_RES-1 and pix_y = V_RES-1: the FSM goes to DONE.
REQ-030 DONE: frame_done = 1 for one cycle, busy = 0, next state IDLE; frame_start in DONE is ignored.
REQ-031 Throughput with spi_ready held high: 4 cycles per pixel.
REQ-032 Throughput with spi_ready held high: 11 cycles of command overhead per frame.
REQ-033 pix_req SHALL never assert outside PREQ.
REQ-034 Exactly H_RES*V_RES pix_req pulses occur per frame.
REQ-035 spi_valid is high only in CMD, PHI and PLO.
REQ-036 spi_ready low stalls the FSM indefinitely with no side effects.
REQ-037 frame_start while busy is ignored and is not queued.
REQ-038 The byte index and the counters are wide enough that they never wrap inside a frame.

Reset
REQ-039 While reset is high at an edge, the FSM goes to IDLE.
REQ-040 Reset values: busy=0, frame_done=0, pix_req=0, spi_valid=0, spi_data=0, spi_dc=0, pix_x=0, pix_y=0, buffer=0.
REQ-041 Reset applied mid-frame (any state) aborts the frame, with no frame_done issued.
REQ-042 The first frame_start after reset restarts at command byte 2A.

Structure
REQ-043 Shared package tetris_lcd_pkg holds the LCD command codes (CASET 2A, RASET 2B, RAMWR 2C), the default H_RES/V_RES values and the FSM state encoding.
REQ-044 One sub-module, tetris_window_cmd_rom: maps a 4-bit index to {dc, byte} for the 11-byte window sequence, parameterised by H_RES/V_RES.

Verification
REQ-045 Reset, frame_start, spi_ready held 1 -> bytes 2A,00,00,00,7F,2B,00,00,00,9F,2C with dc 0,1,1,1,1,0,1,1,1,1,0.
REQ-046 Renderer model with pix_data={pix_x[7:0],pix_y[7:0]} -> 40960 data bytes follow 2C; pixel (5,0) yields 05,00 and pixel (127,159) yields 7F,9F; exactly one frame_done.
REQ-047 Row wrap -> the pix_req after (127,0) is at (0,1); the final pix_req is at (127,159); 20480 pix_req pulses in total.
REQ-048 spi_ready low for 10 cycles during a PHI byte -> spi_data/spi_dc stable, no pix_req, the same byte transfers when ready returns.
REQ-049 frame_start pulsed 3 times while busy -> exactly one frame and one frame_done.
REQ-050 Reset asserted during pixel (10,3) -> next cycle spi_valid=0, busy=0, pix_req=0, no frame_done; a later frame_start emits 2A first.
